// File: rtl/compare_cascade_seq.sv
`default_nettype none
// ============================================================================
//  Module      : compare_cascade_seq
//  Description : Serialises two wide operands one nibble per cycle (LSB first)
//                through a single external 4-bit magnitude comparator. The
//                comparator's greater/less/equal outputs are fed back on its
//                cascade inputs, and the final relation is returned through
//                a valid/ready handshake.
//  Revision    : 1.0  initial release
// ============================================================================
module compare_cascade_seq #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start_valid_i,
    output logic                   start_ready_o,
    input  logic [4*NIBBLES-1:0]   op_a_i,
    input  logic [4*NIBBLES-1:0]   op_b_i,
    output logic [3:0]             cmp_a_o,
    output logic [3:0]             cmp_b_o,
    output logic                   cmp_igb_o,
    output logic                   cmp_ilb_o,
    output logic                   cmp_ieb_o,
    input  logic                   cmp_fgb_i,
    input  logic                   cmp_flb_i,
    input  logic                   cmp_feb_i,
    output logic                   res_valid_o,
    input  logic                   res_ready_i,
    output logic                   res_gt_o,
    output logic                   res_lt_o,
    output logic                   res_eq_o,
    output logic                   res_err_o,
    output logic                   busy_o
);

    localparam int c_W     = 4 * NIBBLES;
    localparam int c_IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(NIBBLES - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_ONE  = c_IDX_W'(1);
    localparam logic [2:0]         c_CAS_SEED = 3'b001;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state_q;
    logic [c_IDX_W-1:0]   idx_q;
    logic [c_W-1:0]       a_q;
    logic [c_W-1:0]       b_q;
    logic [2:0]           cas_q;        // {gb,lb,eb} presented to the comparator
    logic [3:0]           cmp_a_q;
    logic [3:0]           cmp_b_q;
    logic [2:0]           res_q;        // {gt,lt,eq}
    logic                 res_err_q;
    logic                 res_valid_q;
    logic                 start_ready_q;
    logic                 busy_q;

    // Operands are shifted down one nibble per RUN cycle so the next nibble
    // always sits in bits [3:0]; this avoids a variable-index part select.
    logic [c_W-1:0]       a_shift_d;
    logic [c_W-1:0]       b_shift_d;
    logic [2:0]           cmp_f_d;
    logic                 onehot_d;

    // Next-nibble operands and the comparator result as seen this cycle.
    always_comb begin
        a_shift_d = a_q >> 4;
        b_shift_d = b_q >> 4;
        cmp_f_d   = {cmp_fgb_i, cmp_flb_i, cmp_feb_i};
        onehot_d  = (cmp_f_d == 3'b100) || (cmp_f_d == 3'b010) || (cmp_f_d == 3'b001);
    end

    // Controller FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            idx_q         <= '0;
            a_q           <= '0;
            b_q           <= '0;
            cas_q         <= c_CAS_SEED;
            cmp_a_q       <= 4'h0;
            cmp_b_q       <= 4'h0;
            res_q         <= 3'b000;
            res_err_q     <= 1'b0;
            res_valid_q   <= 1'b0;
            start_ready_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    start_ready_q <= 1'b1;
                    if (start_valid_i && start_ready_q) begin
                        a_q           <= op_a_i;
                        b_q           <= op_b_i;
                        idx_q         <= '0;
                        cas_q         <= c_CAS_SEED;
                        cmp_a_q       <= op_a_i[3:0];
                        cmp_b_q       <= op_b_i[3:0];
                        start_ready_q <= 1'b0;
                        busy_q        <= 1'b1;
                        state_q       <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (idx_q == c_LAST_IDX) begin
                        // Final nibble: the comparator output is the answer.
                        // The cascade register returns to its idle seed so the
                        // comparator inputs read {0,0,1} outside RUN.
                        res_q       <= cmp_f_d;
                        res_err_q   <= !onehot_d;
                        res_valid_q <= 1'b1;
                        cas_q       <= c_CAS_SEED;
                        cmp_a_q     <= 4'h0;
                        cmp_b_q     <= 4'h0;
                        state_q     <= S_DONE;
                    end else begin
                        cas_q   <= cmp_f_d;
                        a_q     <= a_shift_d;
                        b_q     <= b_shift_d;
                        cmp_a_q <= a_shift_d[3:0];
                        cmp_b_q <= b_shift_d[3:0];
                        idx_q   <= idx_q + c_IDX_ONE;
                    end
                end
                S_DONE: begin
                    if (res_ready_i) begin
                        res_valid_q   <= 1'b0;
                        res_q         <= 3'b000;
                        res_err_q     <= 1'b0;
                        idx_q         <= '0;
                        busy_q        <= 1'b0;
                        start_ready_q <= 1'b1;
                        state_q       <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign start_ready_o = start_ready_q;
    assign busy_o        = busy_q;
    assign cmp_a_o       = cmp_a_q;
    assign cmp_b_o       = cmp_b_q;
    assign cmp_igb_o     = cas_q[2];
    assign cmp_ilb_o     = cas_q[1];
    assign cmp_ieb_o     = cas_q[0];
    assign res_valid_o   = res_valid_q;
    assign res_gt_o      = res_q[2];
    assign res_lt_o      = res_q[1];
    assign res_eq_o      = res_q[0];
    assign res_err_o     = res_err_q;

endmodule
`default_nettype wire

// File: tb/tb_compare_cascade_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_compare_cascade_seq
//  Description : Bench for compare_cascade_seq with a behavioural 4-bit
//                comparator attached, a transaction-level reference model
//                and per-cycle output checking.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_compare_cascade_seq;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_valid = 1'b0;
    logic        res_ready = 1'b1;
    logic [15:0] op_a = 16'h0;
    logic [15:0] op_b = 16'h0;
    logic        start_ready, res_valid, busy;
    logic [3:0]  cmp_a, cmp_b;
    logic        cmp_igb, cmp_ilb, cmp_ieb;
    logic        cmp_fgb, cmp_flb, cmp_feb;
    logic        res_gt, res_lt, res_eq, res_err;

    // Comparator fault injection: when enabled every nibble returns fault_val.
    logic        fault_en = 1'b0;
    logic [2:0]  fault_val = 3'b000;

    int total = 0;
    int bad   = 0;

    compare_cascade_seq #(.NIBBLES(N)) dut (
        .clk(clk), .rst_n(rst_n),
        .start_valid_i(start_valid), .start_ready_o(start_ready),
        .op_a_i(op_a), .op_b_i(op_b),
        .cmp_a_o(cmp_a), .cmp_b_o(cmp_b),
        .cmp_igb_o(cmp_igb), .cmp_ilb_o(cmp_ilb), .cmp_ieb_o(cmp_ieb),
        .cmp_fgb_i(cmp_fgb), .cmp_flb_i(cmp_flb), .cmp_feb_i(cmp_feb),
        .res_valid_o(res_valid), .res_ready_i(res_ready),
        .res_gt_o(res_gt), .res_lt_o(res_lt), .res_eq_o(res_eq),
        .res_err_o(res_err), .busy_o(busy)
    );

    always #5 clk = ~clk;

    // Behavioural 4-bit magnitude comparator with cascade pass-through.
    always_comb begin
        logic [2:0] f;
        if (fault_en)          f = fault_val;
        else if (cmp_a > cmp_b) f = 3'b100;
        else if (cmp_a < cmp_b) f = 3'b010;
        else                    f = {cmp_igb, cmp_ilb, cmp_ieb};
        {cmp_fgb, cmp_flb, cmp_feb} = f;
    end

    function automatic logic [2:0] rel(input int unsigned a, input int unsigned b);
        if (a > b) return 3'b100;
        if (a < b) return 3'b010;
        return 3'b001;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: m_cnt is the number of cycles since acceptance
    // (0 = idle, 1..N = nibble cycles, N+1 = result pending).
    int          m_cnt = 0;
    bit          m_ready = 1'b0, m_valid = 1'b0, m_err = 1'b0, m_fault = 1'b0;
    logic [2:0]  m_res = 3'b000, m_fval = 3'b000;
    int unsigned m_a = 0, m_b = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_cnt = 0; m_ready = 0; m_valid = 0; m_res = 3'b000; m_err = 0;
        end else if (m_cnt == 0) begin
            if (m_ready && start_valid) begin
                m_a = op_a; m_b = op_b; m_fault = fault_en; m_fval = fault_val;
                m_cnt = 1; m_ready = 0;
            end else begin
                m_ready = 1;
            end
        end else if (m_cnt <= N) begin
            m_cnt++;
            if (m_cnt == N + 1) begin
                m_valid = 1;
                m_res   = m_fault ? m_fval : rel(m_a, m_b);
                m_err   = ($countones(m_res) != 1);
            end
        end else if (res_ready) begin
            m_cnt = 0; m_valid = 0; m_res = 3'b000; m_err = 0; m_ready = 1;
        end
    end

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge clk) begin
        int          k;
        int unsigned mask;
        logic [3:0]  ea, eb;
        logic [2:0]  ec;
        chk("start_ready", start_ready, m_ready);
        chk("busy", busy, m_cnt != 0);
        chk("res_valid", res_valid, m_valid);
        if (m_valid) begin
            chk("res_rel", {res_gt, res_lt, res_eq}, m_res);
            chk("res_err", res_err, m_err);
        end
        if (m_cnt >= 1 && m_cnt <= N) begin
            k    = m_cnt - 1;
            mask = (32'd1 << (4 * k)) - 32'd1;
            ea   = 4'((m_a >> (4 * k)) & 32'hF);
            eb   = 4'((m_b >> (4 * k)) & 32'hF);
            ec   = (m_fault && k > 0) ? m_fval : rel(m_a & mask, m_b & mask);
        end else begin
            ea = 4'h0; eb = 4'h0; ec = 3'b001;
        end
        chk("cmp_a", cmp_a, ea);
        chk("cmp_b", cmp_b, eb);
        chk("cascade", {cmp_igb, cmp_ilb, cmp_ieb}, ec);
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // One directed operation; latency counted with the acceptance cycle as 0.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          input logic [2:0] exp, input logic exp_err, input string nm);
        int n;
        n = 0;
        while (!start_ready && n < 50) begin step(); n++; end
        chk({nm, "_ready_wait"}, n < 50, 1);
        op_a = a; op_b = b; start_valid = 1'b1;
        step();
        start_valid = 1'b0;
        op_a = 16'($urandom); op_b = 16'($urandom);
        n = 1;
        while (!res_valid && n < 50) begin step(); n++; end
        chk({nm, "_latency"}, n, N + 1);
        chk({nm, "_rel"}, {res_gt, res_lt, res_eq}, exp);
        chk({nm, "_err"}, res_err, exp_err);
    endtask

    initial begin
        rst_n = 1'b0;
        step();
        step();
        chk("rst_ready", start_ready, 0);
        chk("rst_valid", res_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cmp_a", cmp_a, 0);
        chk("rst_cascade", {cmp_igb, cmp_ilb, cmp_ieb}, 3'b001);
        rst_n = 1'b1;
        step();
        chk("post_rst_ready", start_ready, 1);

        run_op(16'h1234, 16'h1234, 3'b001, 1'b0, "eq");
        run_op(16'h1235, 16'h1234, 3'b100, 1'b0, "lsb_gt");
        run_op(16'h1234, 16'h1235, 3'b010, 1'b0, "lsb_lt");
        run_op(16'h8000, 16'h7FFF, 3'b100, 1'b0, "msb_gt");
        run_op(16'h0FFF, 16'h1000, 3'b010, 1'b0, "msb_lt");

        // Back-pressure: result must hold while start_valid pulses are ignored.
        step();
        res_ready = 1'b0;
        run_op(16'hABCD, 16'hABCE, 3'b010, 1'b0, "bp");
        for (int i = 0; i < 6; i++) begin
            start_valid = 1'($urandom_range(0, 1));
            step();
            chk("bp_hold_valid", res_valid, 1);
            chk("bp_hold_busy", busy, 1);
            chk("bp_hold_rel", {res_gt, res_lt, res_eq}, 3'b010);
        end
        start_valid = 1'b0;
        res_ready = 1'b1;
        step();
        chk("bp_release_ready", start_ready, 1);
        chk("bp_release_valid", res_valid, 0);
        run_op(16'h0001, 16'h0000, 3'b100, 1'b0, "after_bp");

        // Reset during the second nibble cycle.
        step();
        op_a = 16'h5555; op_b = 16'hAAAA; start_valid = 1'b1;
        step();
        start_valid = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        chk("midrst_ready", start_ready, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_valid", res_valid, 0);
        chk("midrst_cmp_a", cmp_a, 0);
        chk("midrst_cascade", {cmp_igb, cmp_ilb, cmp_ieb}, 3'b001);
        rst_n = 1'b1;
        run_op(16'hFFFF, 16'h0000, 3'b100, 1'b0, "post_midrst");

        // Faulty comparator outputs.
        step();
        fault_en = 1'b1; fault_val = 3'b110;
        run_op(16'h1234, 16'h1234, 3'b110, 1'b1, "fault110");
        step();
        fault_val = 3'b000;
        run_op(16'h4321, 16'h1234, 3'b000, 1'b1, "fault000");
        step();
        fault_en = 1'b0;

        // Randomised traffic, back-pressure and occasional resets.
        for (int i = 0; i < 800; i++) begin
            int sel;
            start_valid = 1'($urandom_range(0, 1));
            res_ready   = 1'($urandom_range(0, 1));
            op_a        = 16'($urandom);
            sel         = int'($urandom_range(0, 3));
            if (sel == 0)      op_b = op_a;
            else if (sel == 1) op_b = op_a ^ (16'd1 << $urandom_range(0, 15));
            else               op_b = 16'($urandom);
            rst_n = ($urandom_range(0, 99) != 0);
            step();
        end

        rst_n = 1'b1; start_valid = 1'b0; res_ready = 1'b1;
        repeat (10) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/compare_cascade_seq.md
# compare_cascade_seq

Sequential cascade controller for the 4-bit magnitude comparator stage. It accepts two wide operands and feeds them one nibble per cycle into a single 4-bit comparator, LSB nibble first. Each cycle it captures the comparator's greater/less/equal outputs and returns them on the comparator's cascade inputs for the next nibble. After the MSB nibble it presents the final relation through a valid/ready handshake, replacing a ripple chain of comparators with one comparator plus this block.

## Interface
- NIBBLES, 4, operand width in nibbles (≥1); operand width W = 4*NIBBLES.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous, active-low reset. One clock; reset is synchronous and active-low.
- start_valid  in  1  operands valid.
- start_ready  out  1  block can accept operands (high only in IDLE).
- op_a  in  W  operand A.
- op_b  in  W  operand B.
- cmp_a  out  4  nibble of A driven to comparator A3..A0.
- cmp_b  out  4  nibble of B driven to comparator B3..B0.
- cmp_igb, cmp_ilb, cmp_ieb  out  1 each  cascade inputs to comparator (IAGB/IALB/IAEB).
- cmp_fgb, cmp_flb, cmp_feb  in  1 each  comparator outputs (FAGB/FALB/FAEB), combinational from cmp_* outputs.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res_gt, res_lt, res_eq  out  1 each  final relation A>B, A<B, A==B.
- res_err  out  1  captured final relation not exactly one-hot.
- busy  out  1  high in RUN or DONE.

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE.
- IDLE:
  - start_ready=1.
  - On start_valid, latch op_a and op_b, set nibble index idx=0, seed cascade register {gb,lb,eb}={0,0,1}, and go to RUN.
- RUN:
  - Drive cmp_a=a_reg[4*idx+3:4*idx] and cmp_b likewise.
  - Drive cascade outputs from the cascade register.
  - Every cycle, register {cmp_fgb,cmp_flb,cmp_feb} into the cascade register.
  - If idx==NIBBLES-1, go to DONE; else idx+1.
- DONE:
  - res_valid=1; res_gt/lt/eq = cascade register; res_err = !(exactly one of the three set).
  - Outputs are held stable until res_ready=1, then go to IDLE.
- Outside RUN: cmp_a=cmp_b=0, cascade outputs={0,0,1}.
- start_valid is ignored outside IDLE; operands may change freely after acceptance.
- The block performs no arithmetic of its own. The relation is decided by the comparator: a higher nibble difference overrides the cascade, and equal nibbles pass the cascade through.
- Reset asserted in any state aborts the operation. No result is emitted and all registers take reset values.

## Timing
- Reset values:
  - state=IDLE, idx=0, cascade register={0,0,1}.
  - res_valid=0, res_gt=res_lt=res_eq=0, res_err=0, busy=0.
  - start_ready=1 after the first cycle with rst_n=1; start_ready=0 while rst_n=0.
  - cmp_a=cmp_b=0; cascade outputs={0,0,1}.
- Acceptance edge T (start_valid & start_ready): RUN occupies cycles T+1 .. T+NIBBLES, one nibble per cycle.
- res_valid rises at T+NIBBLES+1, so latency from acceptance to result is NIBBLES+1 cycles.
- Result handshake completes on the edge where res_valid & res_ready. res_valid is 0 the next cycle and start_ready is 1.
- Next accept is possible one cycle after the result handshake. Throughput is one operation per NIBBLES+2 cycles with res_ready held high.
- The comparator path is combinational within one cycle: cmp_* outputs are registered, and cmp_f* is sampled at the next edge.
- NIBBLES=1: a single RUN cycle, then DONE.

## Test plan
- NIBBLES=4, A=0x1234, B=0x1234, res_ready=1 → res_eq=1, res_gt=res_lt=0, res_err=0. res_valid rises exactly 5 cycles after acceptance.
- A=0x1235, B=0x1234 → res_gt=1: the LSB-only difference propagates through the equal nibbles. A=0x1234, B=0x1235 → res_lt=1.
- A=0x8000, B=0x7FFF → res_gt=1: the MSB decision overrides the prior lt cascade. A=0x0FFF, B=0x1000 → res_lt=1.
- Back-pressure: hold res_ready=0 for 6 cycles.
  - Expected: res_valid and the res_* outputs stay stable, busy=1, and start_valid pulses are ignored.
  - Expected: after res_ready=1 for one cycle, IDLE is reached and the next operands are accepted.
- Reset mid-RUN: deassert rst_n at the 2nd RUN cycle.
  - Expected: the next cycle shows all reset values, with no res_valid pulse.
  - Expected: a new op A=0xFFFF, B=0x0000 completes with res_gt=1.
- Faulty comparator model returning {1,1,0} on the final nibble → res_err=1 with res_gt=res_lt=1. A model returning {0,0,0} → res_err=1.
